// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the JPEG decoder IDCT coefficient buffer:
// bank states, block geometry and small helpers used by the controller.
package aq_djpeg_pkg;

    localparam int BLOCK_COEFS = 64;
    localparam int HALF_COEFS  = BLOCK_COEFS / 2;
    localparam int READ_LAST   = 31;

    localparam logic [4:0] READ_LAST_ADDR = 5'(READ_LAST);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

    // A bank holding a completed block, whether or not the IDCT has started on it.
    function automatic logic bank_is_loaded(input bank_state_t s);
        return (s == BANK_FULL) || (s == BANK_READING);
    endfunction

endpackage

// File: rtl/aq_djpeg_idct_bank_ram.sv
// Simple dual-port coefficient RAM: one write port, one registered read port.
// Address is {bank, 5-bit index}; one instance per half-block (rows 0-3 / 4-7).
module aq_djpeg_idct_bank_ram
    import aq_djpeg_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [5:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [5:0]    rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2*HALF_COEFS];

    // NOTE: the array has no reset; stale words are masked off by the
    // written-mask in the controller, so clearing them would only cost logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/aq_djpeg_idct_bufctl.sv
// Ping-pong coefficient buffer between dequantiser and IDCT: collects sparse
// coefficients per 8x8 block, zero-fills unwritten entries, hands banks to the IDCT.
module aq_djpeg_idct_bufctl
    import aq_djpeg_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ProcessInit,
    input  logic          WrEnable,
    input  logic [5:0]    WrAddress,
    input  logic [DW-1:0] WrData,
    input  logic          WrBlockEnd,
    output logic          WrFull,
    output logic          Overflow,
    output logic          IdctEnable,
    input  logic          IdctRead,
    input  logic [4:0]    IdctAddress,
    output logic [DW-1:0] IdctDataA,
    output logic [DW-1:0] IdctDataB
);

    bank_state_t            state [2];
    logic [BLOCK_COEFS-1:0] mask  [2];
    logic                   wp;
    logic                   rp;
    logic                   overflow;
    logic                   mask_a_q;
    logic                   mask_b_q;

    logic                   wr_full;
    logic                   idct_enable;
    logic                   wr_take;
    logic                   end_take;
    logic                   rd_take;
    logic                   rd_release;
    logic [DW-1:0]          ram_a;
    logic [DW-1:0]          ram_b;

    assign wr_full     = bank_is_loaded(state[wp]);
    assign idct_enable = bank_is_loaded(state[rp]);

    // Writer traffic is dropped entirely while the write bank is occupied.
    assign wr_take    = WrEnable   && !wr_full;
    assign end_take   = WrBlockEnd && !wr_full;
    assign rd_take    = IdctRead   && idct_enable;
    assign rd_release = rd_take    && (IdctAddress == READ_LAST_ADDR);

    // NOTE: all state below uses non-blocking assignments so every bank
    // update in a cycle sees the same pre-edge pointers and states.
    always_ff @(posedge clk) begin
        if (!rst || ProcessInit) begin
            state[0] <= BANK_EMPTY;
            state[1] <= BANK_EMPTY;
            mask[0]  <= '0;
            mask[1]  <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_full && (WrEnable || WrBlockEnd)) begin
                overflow <= 1'b1;
            end

            // Write side and read side never touch the same bank in one cycle:
            // the write bank is never loaded, the read bank always is.
            if (wr_take) begin
                mask[wp][WrAddress] <= 1'b1;
            end
            if (end_take) begin
                state[wp] <= BANK_FULL;
                wp        <= ~wp;
            end else if (wr_take && state[wp] == BANK_EMPTY) begin
                state[wp] <= BANK_FILLING;
            end

            if (rd_release) begin
                state[rp] <= BANK_EMPTY;
                mask[rp]  <= '0;
                rp        <= ~rp;
            end else if (rd_take && state[rp] == BANK_FULL) begin
                state[rp] <= BANK_READING;
            end
        end
    end

    // Mask bits are sampled alongside the RAM read so the last word of a bank
    // is still delivered after the bank has been released.
    always_ff @(posedge clk) begin
        if (!rst || ProcessInit) begin
            mask_a_q <= 1'b0;
            mask_b_q <= 1'b0;
        end else if (IdctRead) begin
            mask_a_q <= mask[rp][{1'b0, IdctAddress}];
            mask_b_q <= mask[rp][{1'b1, IdctAddress}];
        end
    end

    aq_djpeg_idct_bank_ram #(.DW(DW)) u_ram_a (
        .clk     (clk),
        .wr_en   (wr_take && !WrAddress[5]),
        .wr_addr ({wp, WrAddress[4:0]}),
        .wr_data (WrData),
        .rd_en   (IdctRead),
        .rd_addr ({rp, IdctAddress}),
        .rd_data (ram_a)
    );

    aq_djpeg_idct_bank_ram #(.DW(DW)) u_ram_b (
        .clk     (clk),
        .wr_en   (wr_take && WrAddress[5]),
        .wr_addr ({wp, WrAddress[4:0]}),
        .wr_data (WrData),
        .rd_en   (IdctRead),
        .rd_addr ({rp, IdctAddress}),
        .rd_data (ram_b)
    );

    assign IdctDataA  = mask_a_q ? ram_a : '0;
    assign IdctDataB  = mask_b_q ? ram_b : '0;
    assign WrFull     = wr_full;
    assign Overflow   = overflow;
    assign IdctEnable = idct_enable;

endmodule

// File: doc/aq_djpeg_idct_bufctl.md
# aq_djpeg_idct_bufctl

Ping-pong coefficient buffer controller that sits between the dequantiser and the IDCT core. It collects sparse, arbitrary-order dequantised coefficients for one 8x8 block into one of two banks, with unwritten entries reading as zero. It presents a completed bank to the IDCT through the existing enable/read/address/dual-data handshake and frees the bank once the IDCT has consumed it. The controller owns bank sequencing, back-pressure and zero-fill.

## Interface
Parameters:
- DW, 16, coefficient width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- ProcessInit  in  1  synchronous clear of all bank state, same effect as reset.
- WrEnable  in  1  coefficient write strobe.
- WrAddress  in  6  natural (row-major) coefficient index 0..63.
- WrData  in  DW  coefficient value.
- WrBlockEnd  in  1  current block complete; may coincide with WrEnable.
- WrFull  out  1  no bank available for writing; writer must stall.
- Overflow  out  1  sticky: a WrEnable or WrBlockEnd arrived while WrFull.
- IdctEnable  out  1  a full bank is available to the IDCT (drives IDCT DataInEnable).
- IdctRead  in  1  IDCT read strobe.
- IdctAddress  in  5  IDCT read address.
- IdctDataA  out  DW  coefficient [IdctAddress] (rows 0-3).
- IdctDataB  out  DW  coefficient [IdctAddress+32] (rows 4-7).

## Operation
- Each bank (0/1) has a state: EMPTY, FILLING, FULL or READING. It also has a 64-bit written-mask.
- Write pointer wp and read pointer rp are 1 bit each. Both reset to 0.
- Write bank wp:
  - EMPTY -> FILLING on the first WrEnable.
  - FILLING or EMPTY -> FULL on WrBlockEnd; an empty block is legal and all entries read 0.
  - wp toggles on WrBlockEnd.
- Read bank rp:
  - FULL -> READING on the first IdctRead.
  - READING -> EMPTY on IdctRead with IdctAddress==31. At the same time, the mask clears and rp toggles.
  - The IDCT must issue address 31 last.
- A WrEnable sets mask[WrAddress] and writes the RAM. A repeated address within a block: last write wins.
- Read data = mask bit ? RAM word : 0, evaluated per half (A uses mask[addr], B uses mask[addr+32]).
- WrFull = state[wp] is FULL or READING.
- While WrFull:
  - WrEnable and WrBlockEnd are ignored (no RAM, mask or state change).
  - Overflow is set.
- IdctEnable = state[rp] is FULL or READING.
- Simultaneous block end on bank X and release of bank Y: both take effect in the same cycle, with no lost event.
- ProcessInit, or rst low, mid-block:
  - Both banks go EMPTY, masks clear, wp=rp=0, Overflow=0.
  - RAM contents are don't-care, because the masks gate them.

## Timing
- Reset values:
  - WrFull=0, Overflow=0, IdctEnable=0, IdctDataA=0, IdctDataB=0.
  - All banks EMPTY.
- Write to visible (WrBlockEnd in cycle t):
  - State[wp] becomes FULL at t+1.
  - IdctEnable rises at t+1 if that bank is rp.
- Read latency: IdctDataA/B are registered and valid the cycle after IdctRead. They hold their value when there is no read.
- Release (IdctRead with address 31 at cycle t):
  - The bank is EMPTY at t+1, and WrFull deasserts at t+1 if wp pointed to it.
  - If the other bank is already FULL, IdctEnable stays high through t+1 without a gap; otherwise it falls at t+1.
- The final data word of a bank is still delivered at t+1 after release.
- Throughput: one coefficient write per cycle; one A/B pair per cycle on the read side.

## Structure
- Shared package aq_djpeg_pkg holds:
  - the bank-state enum (EMPTY, FILLING, FULL, READING);
  - the constants BLOCK_COEFS=64 and READ_LAST=31.
- Sub-module aq_djpeg_idct_bank_ram is a simple dual-port RAM: one write port and one registered read port, 64 words (bank bit + 5-bit address), DW wide.
- Two instances are used: the A half takes WrAddress[5]==0, the B half takes WrAddress[5]==1.
- Control (states, masks, pointers, zero-gating) lives in the top module.

## Test plan
- Reset: hold rst low 2 cycles → all outputs 0. Write a block with coefficient [0]=100 and [63]=-5, then WrBlockEnd → IdctEnable=1 the next cycle. Reading addresses 0..31 returns A[0]=100, B[31]=-5, all else 0.
- Sparse / duplicate: write [10]=7, then [10]=9 → the read at address 10 returns A=9. Coefficient [42] unwritten → B at address 10 is 0.
- Back-pressure: complete two blocks with no IDCT reads → WrFull=1. A further WrEnable sets Overflow=1 and leaves both banks' data unchanged.
- Back-to-back: bank1 FULL while bank0 is being read; release at address 31 → IdctEnable stays high and the next read returns bank1 data.
- Simultaneous: WrBlockEnd on bank1 in the same cycle as the address-31 read of bank0 → the next cycle has bank1 FULL, bank0 EMPTY, WrFull=0.
- Init mid-block: pulse ProcessInit after 20 writes → the next block reads only its own writes (others 0), and Overflow=0.
